trivium_keystream_gen: RTL and testbench
========================================

Name: trivium_keystream_gen

Overview:
- Producer side of the keystream handshake (keystream_read / keystream_byte / keystream_valid) used by the UART encryption top level.
- Implements the Trivium cipher: 288-bit state, 1152-round warm-up, then 8-bit keystream bytes.
- Holds each byte stable until the consumer reads it; a one-byte prefetch slot allows back-to-back reads.
- Auto-initialises from default key/IV after reset and accepts runtime rekeying through a load strobe.

Parameters:
- ROUNDS_PER_CLK, 8, Trivium rounds evaluated per clock; legal values 1, 2, 4, 8.
- DEFAULT_KEY, 80'h0, key used for the automatic init after reset.
- DEFAULT_IV, 80'h0, IV used for the automatic init after reset.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- load  input  1  one-cycle strobe; latch key_in/iv_in and restart init
- key_in  input  80  key, sampled only when load=1
- iv_in  input  80  IV, sampled only when load=1
- keystream_read  input  1  consume current byte; honoured only while keystream_valid=1
- keystream_byte  output  8  current keystream byte, registered
- keystream_valid  output  1  keystream_byte holds an unconsumed byte
- busy  output  1  warm-up in progress

Behaviour:
- Reset: while rst_n=0, all of the following hold asynchronously:
  - keystream_valid=0, keystream_byte=0, busy=1.
  - Prefetch slot empty.
  - State loaded from DEFAULT_KEY/DEFAULT_IV.
  - Round counter=0, FSM=INIT.
- Bit mapping: K_i = key[i-1], IV_i = iv[i-1], i=1..80.
- State load:
  - s1..s93 = K1..K80, then 13 zeros.
  - s94..s177 = IV1..IV80, then 4 zeros.
  - s178..s288 = 108 zeros, then 1,1,1.
- Round:
  - t1=s66^s93; t2=s162^s177; t3=s243^s288; z=t1^t2^t3.
  - t1^=s91&s92^s171; t2^=s175&s176^s264; t3^=s286&s287^s69.
  - Shift: s1..s93 <= t3,s1..s92; s94..s177 <= t1,s94..s176; s178..s288 <= t2,s178..s287.
  - Rounds chain combinationally ROUNDS_PER_CLK deep per clock.
- Byte packing: the first z bit generated after init goes to bit 0 (LSB first); 8 bits form one byte.
- FSM:
  - INIT: advance state ROUNDS_PER_CLK rounds per clock, discard z; counter counts to 1152/ROUNDS_PER_CLK cycles; then busy<=0 and go to GEN.
  - GEN: advance state and shift z into the accumulator; after 8/ROUNDS_PER_CLK cycles a byte is complete.
    - If the output register is empty, or is being read this cycle, the byte goes to keystream_byte and keystream_valid<=1.
    - Otherwise the byte goes to the prefetch slot and the FSM goes to STALL.
  - STALL: cipher state frozen; on keystream_read the prefetch byte moves to the output register in the same edge (no bubble), the slot empties, and the FSM returns to GEN.
- Read:
  - keystream_read with keystream_valid=1 consumes the byte.
  - keystream_valid falls on the next edge unless a replacement byte (prefetch or just-completed) loads on that edge.
  - keystream_read with keystream_valid=0 is ignored.
- Latency, ROUNDS_PER_CLK=8, counting the first edge with rst_n=1 as edge 1:
  - busy falls at edge 144.
  - keystream_valid rises at edge 145.
  - Sustained throughput is 1 byte/cycle.
  - General case: valid at (1152+8)/ROUNDS_PER_CLK.
- Load, accepted in any state:
  - The next edge clears keystream_valid and the prefetch slot.
  - busy<=1; state reloaded from key_in/iv_in; counter=0; FSM=INIT.
  - Load wins over a simultaneous keystream_read.
  - A second load during INIT restarts the count.
- keystream_byte is unchanged while keystream_valid=0, except on reset (cleared to 0).
- No byte is ever duplicated or skipped: the consumed sequence equals the raw Trivium output sequence.
- Reset mid-operation: all outputs return to reset values immediately; full init reruns after release.

Test Plan:
- Reset release, defaults, ROUNDS_PER_CLK=8:
  - keystream_valid=0 through edge 144 and 1 at edge 145.
  - busy 1→0 at edge 144.
- Known answer, key=0/iv=0: read 32 bytes; each matches the bench Trivium golden model using the same bit mapping and LSB-first packing.
- Backpressure:
  - Hold read=0 for 100 cycles: keystream_byte stable and prefetch full.
  - Then assert read every cycle: keystream_valid stays 1 continuously and 64 consecutive bytes match golden with no gaps or repeats.
- Rekey mid-stream:
  - Pulse load with key=80'h0123456789ABCDEF0123, iv=80'hFEDCBA9876543210FEDC.
  - Next edge: valid=0, busy=1.
  - valid returns 145 edges after the load edge; bytes match golden from byte 0 of the new key.
- Corner cases:
  - read while valid=0 → no byte lost.
  - load+read on the same cycle → load wins, stale byte dropped.
  - rst_n low at edge 50 of INIT → outputs reset asynchronously; valid at edge 145 after re-release.
- ROUNDS_PER_CLK=1 build: first valid at edge 1160; 8 cycles/byte; byte stream identical to the ROUNDS_PER_CLK=8 build.

Source files
------------

// File: rtl/trivium_keystream_gen.sv
// Trivium keystream producer: 288-bit cipher state, 1152-round warm-up, then LSB-first
// keystream bytes behind a valid/read handshake with a one-byte prefetch slot.
module trivium_keystream_gen #(
    parameter int          ROUNDS_PER_CLK = 8,
    parameter logic [79:0] DEFAULT_KEY    = 80'h0,
    parameter logic [79:0] DEFAULT_IV     = 80'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [79:0] key_in,
    input  logic [79:0] iv_in,
    input  logic        keystream_read,
    output logic [7:0]  keystream_byte,
    output logic        keystream_valid,
    output logic        busy
);

    localparam logic [10:0] INIT_LAST = 11'(1152 / ROUNDS_PER_CLK - 1);
    localparam logic [10:0] BYTE_LAST = 11'(8 / ROUNDS_PER_CLK - 1);

    typedef enum logic [1:0] {INIT, GEN, STALL} state_t;

    function automatic logic [287:0] load_state(input logic [79:0] key, input logic [79:0] iv);
        logic [287:0] s;
        s          = '0;
        s[79:0]    = key;
        s[172:93]  = iv;
        s[287:285] = 3'b111;
        return s;
    endfunction

    // Returns {z, next_state}; bit 0 of the vector is s1.
    function automatic logic [288:0] trivium_round(input logic [287:0] s);
        logic t1, t2, t3, z;
        t1 = s[65] ^ s[92];
        t2 = s[161] ^ s[176];
        t3 = s[242] ^ s[287];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (s[90] & s[91]) ^ s[170];
        t2 = t2 ^ (s[174] & s[175]) ^ s[263];
        t3 = t3 ^ (s[285] & s[286]) ^ s[68];
        return {z, s[286:177], t2, s[175:93], t1, s[91:0], t3};
    endfunction

    state_t        st_q, st_d;
    logic [287:0]  s_q, s_d, s_adv;
    logic [288:0]  rr;
    logic [10:0]   cnt_q, cnt_d;
    logic [7:0]    acc_q, acc_d;
    logic [7:0]    byte_q, byte_d;
    logic [7:0]    pf_q, pf_d;
    logic          pf_full_q, pf_full_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic [ROUNDS_PER_CLK-1:0]   chunk;
    logic [ROUNDS_PER_CLK+7:0]   cat;
    logic [7:0]    byte_w;
    logic          rd;

    always_comb begin
        s_adv = s_q;
        rr    = '0;
        chunk = '0;
        for (int r = 0; r < ROUNDS_PER_CLK; r++) begin
            rr       = trivium_round(s_adv);
            chunk[r] = rr[288];
            s_adv    = rr[287:0];
        end
        // Earliest z bits sink toward bit 0 as later chunks enter from the top.
        cat    = {chunk, acc_q};
        byte_w = cat[ROUNDS_PER_CLK +: 8];
        rd     = keystream_read & valid_q;
    end

    always_comb begin
        st_d      = st_q;
        s_d       = s_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        byte_d    = byte_q;
        pf_d      = pf_q;
        pf_full_d = pf_full_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        if (load) begin
            st_d      = INIT;
            s_d       = load_state(key_in, iv_in);
            cnt_d     = '0;
            busy_d    = 1'b1;
            valid_d   = 1'b0;
            pf_full_d = 1'b0;
        end else begin
            case (st_q)
                INIT: begin
                    s_d = s_adv;
                    if (cnt_q == INIT_LAST) begin
                        cnt_d  = '0;
                        busy_d = 1'b0;
                        st_d   = GEN;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
                GEN: begin
                    s_d   = s_adv;
                    acc_d = byte_w;
                    if (rd) valid_d = 1'b0;
                    if (cnt_q == BYTE_LAST) begin
                        cnt_d = '0;
                        if (!valid_q || rd) begin
                            byte_d  = byte_w;
                            valid_d = 1'b1;
                        end else begin
                            pf_d      = byte_w;
                            pf_full_d = 1'b1;
                            st_d      = STALL;
                        end
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
                STALL: begin
                    // Cipher frozen; the prefetched byte replaces the consumed one on the same edge.
                    if (rd && pf_full_q) begin
                        byte_d    = pf_q;
                        pf_full_d = 1'b0;
                        st_d      = GEN;
                    end
                end
                default: st_d = INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= INIT;
            s_q       <= load_state(DEFAULT_KEY, DEFAULT_IV);
            cnt_q     <= '0;
            acc_q     <= '0;
            byte_q    <= '0;
            pf_q      <= '0;
            pf_full_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            st_q      <= st_d;
            s_q       <= s_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            byte_q    <= byte_d;
            pf_q      <= pf_d;
            pf_full_q <= pf_full_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign keystream_byte  = byte_q;
    assign keystream_valid = valid_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_trivium_keystream_gen.sv
// Scoreboard bench for trivium_keystream_gen: a bit-serial Trivium model fills the expected
// byte queue; bytes are popped whenever the bench consumes one from the DUT.
module tb_trivium_keystream_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, load, keystream_read, keystream_valid, busy;
    logic [79:0] key_in, iv_in;
    logic [7:0]  keystream_byte;

    logic        rst1_n, load1, rd1, valid1, busy1;
    logic [7:0]  byte1;

    trivium_keystream_gen #(.ROUNDS_PER_CLK(8)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .key_in(key_in), .iv_in(iv_in),
        .keystream_read(keystream_read), .keystream_byte(keystream_byte),
        .keystream_valid(keystream_valid), .busy(busy)
    );

    trivium_keystream_gen #(.ROUNDS_PER_CLK(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .load(load1), .key_in(80'h0), .iv_in(80'h0),
        .keystream_read(rd1), .keystream_byte(byte1),
        .keystream_valid(valid1), .busy(busy1)
    );

    int         total = 0;
    int         bad   = 0;
    int         nread;
    logic [7:0] sb[$];
    bit         ms[1:288];

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic consume(input string tag, input logic [7:0] got);
        if (sb.size() == 0) chk({tag, "_sb_empty"}, 80'(sb.size()), 80'd1);
        else chk(tag, {72'd0, got}, {72'd0, sb.pop_front()});
        nread++;
    endtask

    task automatic model_round(output bit z);
        bit t1, t2, t3;
        t1 = ms[66] ^ ms[93];
        t2 = ms[162] ^ ms[177];
        t3 = ms[243] ^ ms[288];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
        t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
        t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
        for (int i = 93; i >= 2; i--) ms[i] = ms[i-1];
        ms[1] = t3;
        for (int i = 177; i >= 95; i--) ms[i] = ms[i-1];
        ms[94] = t1;
        for (int i = 288; i >= 179; i--) ms[i] = ms[i-1];
        ms[178] = t2;
    endtask

    task automatic push_golden(input logic [79:0] k, input logic [79:0] iv, input int n);
        bit         z;
        logic [7:0] b;
        sb.delete();
        for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            ms[i]      = k[i-1];
            ms[93 + i] = iv[i-1];
        end
        ms[286] = 1'b1; ms[287] = 1'b1; ms[288] = 1'b1;
        repeat (1152) model_round(z);
        repeat (n) begin
            for (int j = 0; j < 8; j++) begin
                model_round(z);
                b[j] = z;
            end
            sb.push_back(b);
        end
    endtask

    task automatic step(input logic rd);
        keystream_read = rd;
        if (rd && keystream_valid) consume("byte", keystream_byte);
        @(posedge clk);
        #1;
    endtask

    task automatic warmup_check(input string tag);
        for (int e = 1; e <= 145; e++) begin
            step(1'b0);
            chk({tag, "_valid"}, 80'(keystream_valid), 80'(e >= 145));
            chk({tag, "_busy"}, 80'(busy), 80'(e < 144));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] held;
        int         last, n1;
        rst_n = 1'b0; rst1_n = 1'b0; load = 1'b0; load1 = 1'b0; rd1 = 1'b0;
        key_in = '0; iv_in = '0; keystream_read = 1'b0; nread = 0;
        push_golden(80'h0, 80'h0, 200);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 80'(keystream_valid), 80'd0);
        chk("rst_byte", {72'd0, keystream_byte}, 80'd0);
        chk("rst_busy", 80'(busy), 80'd1);

        rst_n = 1'b1;
        warmup_check("warm");

        // Known-answer: 32 bytes read back to back
        for (int c = 0; c < 100 && nread < 32; c++) step(1'b1);
        chk("kat_count", 80'(nread), 80'd32);

        // Backpressure: output holds, slot fills, then full-rate drain
        held = keystream_byte;
        for (int c = 0; c < 100; c++) begin
            step(1'b0);
            chk("bp_hold", {72'd0, keystream_byte}, {72'd0, held});
        end
        chk("bp_valid", 80'(keystream_valid), 80'd1);
        chk("bp_pf_full", 80'(dut.pf_full_q), 80'd1);
        for (int c = 0; c < 64; c++) begin
            chk("stream_valid", 80'(keystream_valid), 80'd1);
            step(1'b1);
        end
        chk("stream_count", 80'(nread), 80'd96);

        // Rekey with a simultaneous read: load must win
        keystream_read = 1'b1;
        load   = 1'b1;
        key_in = 80'h0123456789ABCDEF0123;
        iv_in  = 80'hFEDCBA9876543210FEDC;
        @(posedge clk);
        #1;
        load = 1'b0;
        chk("load_valid", 80'(keystream_valid), 80'd0);
        chk("load_busy", 80'(busy), 80'd1);
        push_golden(80'h0123456789ABCDEF0123, 80'hFEDCBA9876543210FEDC, 40);
        nread = 0;
        for (int k = 1; k <= 145; k++) begin
            step(1'b1);
            chk("rekey_valid", 80'(keystream_valid), 80'(k >= 145));
        end
        for (int c = 0; c < 60 && nread < 16; c++) step(1'b1);
        chk("rekey_count", 80'(nread), 80'd16);

        // Reset in the middle of a warm-up
        keystream_read = 1'b0;
        load   = 1'b1;
        key_in = 80'h0;
        iv_in  = 80'h0;
        @(posedge clk);
        #1;
        load = 1'b0;
        repeat (49) step(1'b0);
        chk("mid_busy", 80'(busy), 80'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 80'(keystream_valid), 80'd0);
        chk("mid_rst_byte", {72'd0, keystream_byte}, 80'd0);
        chk("mid_rst_busy", 80'(busy), 80'd1);
        push_golden(80'h0, 80'h0, 20);
        nread = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        warmup_check("rewarm");
        for (int c = 0; c < 40 && nread < 8; c++) step(1'b1);
        chk("rewarm_count", 80'(nread), 80'd8);

        // Reset while streaming clears outputs without a clock edge
        chk("pre_rst_valid", 80'(keystream_valid), 80'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("live_rst_valid", 80'(keystream_valid), 80'd0);
        chk("live_rst_byte", {72'd0, keystream_byte}, 80'd0);
        chk("live_rst_busy", 80'(busy), 80'd1);
        keystream_read = 1'b0;

        // One-round-per-clock build: same stream, 8 cycles per byte
        push_golden(80'h0, 80'h0, 16);
        nread = 0;
        @(posedge clk);
        #1;
        rst1_n = 1'b1;
        for (int e = 1; e <= 1160; e++) begin
            @(posedge clk);
            #1;
            chk("r1_valid", 80'(valid1), 80'(e >= 1160));
            chk("r1_busy", 80'(busy1), 80'(e < 1152));
        end
        rd1  = 1'b1;
        last = 0;
        n1   = 0;
        for (int c = 0; c < 200 && n1 < 16; c++) begin
            if (valid1) begin
                consume("r1_byte", byte1);
                if (n1 > 0) chk("r1_gap", 80'(c - last), 80'd8);
                last = c;
                n1++;
            end
            @(posedge clk);
            #1;
        end
        chk("r1_count", 80'(n1), 80'd16);
        rd1 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
